// File: rtl/dna_pkg.sv
// Shared definitions for the DNA systolic-array controller:
// FSM state encoding, phase counter width and the filler base codes
// driven toward the PE array whenever no live base is being streamed.
package dna_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int          PHASE_W    = 4;
  localparam logic [3:0]  PHASE_LAST = 4'hF;

  // Filler codes presented to PE0 / the read broadcast outside of RUN
  localparam logic [1:0]  REF_FILL   = 2'b11;
  localparam logic [1:0]  READ_FILL  = 2'b00;

endpackage

// File: rtl/dna_array_ctrl.sv
// Controller for a linear systolic array of NUM_PE alignment PEs.
// Streams ref_len reference bases into PE0 while broadcasting one read
// base per 16 steps, then drains the pipeline for NUM_PE cycles and
// pulses done_o. Step handshakes are combinational so the array can
// advance on the same cycle the streams present valid data.
// Optional feature macro: DNA_MAXSCORE_EN (best-score tracking on max_score_o).
module dna_array_ctrl
  import dna_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  ref_len_i,
  input  logic [2:0]        match_i,
  input  logic [2:0]        mismatch_i,
  input  logic [2:0]        gap_i,
  input  logic              ref_valid_i,
  input  logic [1:0]        ref_base_i,
  output logic              ref_ready_o,
  input  logic              read_valid_i,
  input  logic [1:0]        read_base_i,
  output logic              read_ready_o,
  output logic              pe_rst_o,
  output logic              pe_en_o,
  output logic [1:0]        pe_ref_o,
  output logic [1:0]        pe_read_o,
  output logic [2:0]        pe_match_o,
  output logic [2:0]        pe_mismatch_o,
  output logic [2:0]        pe_gap_o,
  input  logic [31:0]       score_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       max_score_o
);

  localparam int DRAIN_W = (NUM_PE > 1) ? $clog2(NUM_PE + 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(NUM_PE - 1);

  state_t               state_r, state_s;
  logic [PHASE_W-1:0]   phase_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     step_cnt_r;
  logic [DRAIN_W-1:0]   drain_cnt_r;
  logic [2:0]           match_r, mismatch_r, gap_r;
  logic                 abort_rst_r;   // holds pe_rst_o for the cycle after reset/abort
  logic                 run_step_s;
  logic                 last_step_s;

  assign last_step_s = ((step_cnt_r + LEN_W'(1)) == len_r);

  // Next-state decode plus combinational step handshakes toward streams and PEs
  always_comb begin
    state_s      = state_r;
    run_step_s   = 1'b0;
    pe_en_o      = 1'b0;
    ref_ready_o  = 1'b0;
    read_ready_o = 1'b0;
    pe_rst_o     = abort_rst_r;
    pe_ref_o     = REF_FILL;
    pe_read_o    = READ_FILL;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        busy_o   = 1'b1;
        pe_rst_o = 1'b1;
        if (abort_i) begin
          state_s = ST_IDLE;
        end else if (len_r == {LEN_W{1'b0}}) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o     = 1'b1;
        pe_ref_o   = ref_base_i;
        pe_read_o  = read_base_i;
        run_step_s = ref_valid_i && ((phase_r != PHASE_LAST) || read_valid_i);
        if (abort_i) begin
          state_s = ST_IDLE;
        end else if (run_step_s) begin
          pe_en_o      = 1'b1;
          ref_ready_o  = 1'b1;
          read_ready_o = (phase_r == PHASE_LAST);
          if (last_step_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_s = ST_IDLE;
        end else begin
          pe_en_o = 1'b1;
          if (drain_cnt_r == DRAIN_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
      end
      ST_DONE: begin
        busy_o  = 1'b1;
        state_s = ST_IDLE;
        if (abort_i) begin
          done_o = 1'b0;
        end else begin
          done_o = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, run counters and weight/length capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      phase_r     <= {PHASE_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      step_cnt_r  <= {LEN_W{1'b0}};
      drain_cnt_r <= {DRAIN_W{1'b0}};
      match_r     <= 3'd0;
      mismatch_r  <= 3'd0;
      gap_r       <= 3'd0;
      abort_rst_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      abort_rst_r <= (state_r != ST_IDLE) && abort_i;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            len_r      <= ref_len_i;
            match_r    <= match_i;
            mismatch_r <= mismatch_i;
            gap_r      <= gap_i;
          end
        end
        ST_CLEAR: begin
          phase_r     <= {PHASE_W{1'b0}};
          step_cnt_r  <= {LEN_W{1'b0}};
          drain_cnt_r <= {DRAIN_W{1'b0}};
        end
        ST_RUN: begin
          if (pe_en_o) begin
            phase_r    <= phase_r + PHASE_W'(1);
            step_cnt_r <= step_cnt_r + LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (pe_en_o) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
          end
        end
        default: begin
          drain_cnt_r <= drain_cnt_r;
        end
      endcase
    end
  end

  assign pe_match_o    = match_r;
  assign pe_mismatch_o = mismatch_r;
  assign pe_gap_o      = gap_r;

`ifdef DNA_MAXSCORE_EN
  logic [31:0] max_score_r;

  // Best score seen on any array step of the current run (unsigned compare)
  always_ff @(posedge clk) begin
    if (rst) begin
      max_score_r <= 32'd0;
    end else if (state_r == ST_CLEAR) begin
      max_score_r <= 32'd0;
    end else if (pe_en_o && (score_i > max_score_r)) begin
      max_score_r <= score_i;
    end
  end

  assign max_score_o = max_score_r;
`else
  assign max_score_o = 32'd0;
`endif

endmodule

// File: tb/tb_dna_array_ctrl.sv
// Directed self-checking bench for dna_array_ctrl (NUM_PE=16, LEN_W=16).
// Cycle 0 is the IDLE cycle in which start_i is applied; cycle numbers
// below are counted from there.
module tb_dna_array_ctrl;

  localparam int NUM_PE = 16;
  localparam int LEN_W  = 16;
`ifdef DNA_MAXSCORE_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i, abort_i;
  logic [LEN_W-1:0]  ref_len_i;
  logic [2:0]        match_i, mismatch_i, gap_i;
  logic              ref_valid_i, ref_ready_o;
  logic [1:0]        ref_base_i;
  logic              read_valid_i, read_ready_o;
  logic [1:0]        read_base_i;
  logic              pe_rst_o, pe_en_o;
  logic [1:0]        pe_ref_o, pe_read_o;
  logic [2:0]        pe_match_o, pe_mismatch_o, pe_gap_o;
  logic [31:0]       score_i, max_score_o;
  logic              busy_o, done_o;

  dna_array_ctrl #(.NUM_PE(NUM_PE), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .ref_len_i(ref_len_i), .match_i(match_i), .mismatch_i(mismatch_i), .gap_i(gap_i),
    .ref_valid_i(ref_valid_i), .ref_base_i(ref_base_i), .ref_ready_o(ref_ready_o),
    .read_valid_i(read_valid_i), .read_base_i(read_base_i), .read_ready_o(read_ready_o),
    .pe_rst_o(pe_rst_o), .pe_en_o(pe_en_o), .pe_ref_o(pe_ref_o), .pe_read_o(pe_read_o),
    .pe_match_o(pe_match_o), .pe_mismatch_o(pe_mismatch_o), .pe_gap_o(pe_gap_o),
    .score_i(score_i), .busy_o(busy_o), .done_o(done_o), .max_score_o(max_score_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus controls (cycle windows, -1 = unused)
  int ref_lo_a, ref_lo_b, rd_lo_a, rd_lo_b, rd_lo_one, abort_at;
  bit hold_start;
  int sc [64];

  // per-run observations
  int done_at, n_en, n_refr, n_readr, n_rst, n_busy;
  logic [1:0]  ref_at2, read_at2;
  logic [31:0] max_at2;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i      = 1'b0;
    abort_i      = 1'b0;
    ref_valid_i  = 1'b1;
    read_valid_i = 1'b1;
    ref_base_i   = 2'b00;
    read_base_i  = 2'b00;
    score_i      = 32'd0;
  endtask

  task automatic clear_stim();
    ref_lo_a = -1; ref_lo_b = -1; rd_lo_a = -1; rd_lo_b = -1;
    rd_lo_one = -1; abort_at = -1; hold_start = 1'b0;
    for (int i = 0; i < 64; i++) sc[i] = 0;
  endtask

  task automatic apply(input int c);
    logic [31:0] cv;
    cv           = c;
    start_i      = (c == 0) || hold_start;
    ref_valid_i  = !(c >= ref_lo_a && c < ref_lo_b);
    read_valid_i = !((c >= rd_lo_a && c < rd_lo_b) || c == rd_lo_one);
    abort_i      = (c == abort_at);
    ref_base_i   = cv[1:0];
    read_base_i  = ~cv[1:0];
    score_i      = (c < 64) ? sc[c] : 0;
  endtask

  // Launch a run from IDLE and observe it until done_o or the cycle budget
  task automatic watch(input int limit);
    done_at = -1; n_en = 0; n_refr = 0; n_readr = 0; n_rst = 0; n_busy = 0;
    apply(0);
    for (int cyc = 0; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        n_en    += int'(pe_en_o);
        n_refr  += int'(ref_ready_o);
        n_readr += int'(read_ready_o);
        n_rst   += int'(pe_rst_o);
        n_busy  += int'(busy_o);
        if (cyc == 2) begin
          ref_at2 = pe_ref_o; read_at2 = pe_read_o; max_at2 = max_score_o;
        end
        if (done_o) begin
          done_at = cyc;
          break;
        end
      end
      tick();
      apply(cyc + 1);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    clear_stim();
    ref_len_i = '0; match_i = 3'd0; mismatch_i = 3'd0; gap_i = 3'd0;

    // reset with start/abort asserted
    rst = 1'b1; start_i = 1'b1; abort_i = 1'b1;
    tick(); tick();
    @(negedge clk);
    check_val("rst_pe_rst", pe_rst_o, 1);
    check_val("rst_pe_ref", pe_ref_o, 3);
    check_val("rst_pe_read", pe_read_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_en", {pe_en_o, ref_ready_o, read_ready_o}, 0);
    check_val("rst_max", max_score_o, 0);
    check_val("rst_weights", {pe_match_o, pe_mismatch_o, pe_gap_o}, 0);
    tick();
    rst = 1'b0; idle_inputs();
    tick();
    check_val("post_rst_idle", {busy_o, pe_rst_o}, 0);

    // 1: ref_len=4, streams always valid
    ref_len_i = 16'd4; match_i = 3'd1; mismatch_i = 3'd2; gap_i = 3'd3;
    watch(40);
    check_val("t1_done_at", done_at, 22);
    check_val("t1_en", n_en, 20);
    check_val("t1_ref_ready", n_refr, 4);
    check_val("t1_read_ready", n_readr, 0);
    check_val("t1_pe_rst", n_rst, 1);
    check_val("t1_busy", n_busy, 22);
    check_val("t1_pe_ref_run", ref_at2, 2'b10);
    check_val("t1_pe_read_run", read_at2, 2'b01);
    check_val("t1_idle", {busy_o, pe_en_o, pe_rst_o, done_o}, 0);
    check_val("t1_idle_fill", {pe_ref_o, pe_read_o}, 4'b1100);
    match_i = 3'd7; mismatch_i = 3'd6; gap_i = 3'd5;
    tick();
    check_val("t1_weights_held", {pe_match_o, pe_mismatch_o, pe_gap_o}, {3'd1, 3'd2, 3'd3});

    // 2: ref_valid low cycles 3..5, start held high throughout
    clear_stim(); ref_lo_a = 3; ref_lo_b = 6; hold_start = 1'b1;
    watch(60);
    check_val("t2_done_at", done_at, 25);
    check_val("t2_en", n_en, 20);
    check_val("t2_ref_ready", n_refr, 4);
    check_val("t2_weights", {pe_match_o, pe_mismatch_o, pe_gap_o}, {3'd7, 3'd6, 3'd5});

    // 3: ref_len=20, read invalid at phase 15 (cycles 17,18) and at phase 3
    clear_stim(); ref_len_i = 16'd20; rd_lo_a = 17; rd_lo_b = 19; rd_lo_one = 5;
    watch(80);
    check_val("t3_done_at", done_at, 40);
    check_val("t3_en", n_en, 36);
    check_val("t3_ref_ready", n_refr, 20);
    check_val("t3_read_ready", n_readr, 1);

    // 4: ref_len=0 goes straight to drain
    clear_stim(); ref_len_i = 16'd0;
    watch(40);
    check_val("t4_done_at", done_at, 18);
    check_val("t4_en", n_en, 16);
    check_val("t4_ref_ready", n_refr, 0);

    // 5: abort on RUN step 2, then a fresh run
    clear_stim(); ref_len_i = 16'd4; abort_at = 3;
    watch(10);
    check_val("t5_no_done", done_at, -1);
    check_val("t5_en", n_en, 1);
    check_val("t5_pe_rst", n_rst, 2);
    check_val("t5_busy", n_busy, 3);
    clear_stim();
    watch(40);
    check_val("t5_restart_done", done_at, 22);

    // 6: best score 5,9,3 then a second run 4,2,1
    clear_stim(); ref_len_i = 16'd3; sc[2] = 5; sc[3] = 9; sc[4] = 3;
    watch(40);
    check_val("t6_done_at", done_at, 21);
    check_val("t6_max", max_score_o, MAX_EN ? 32'd9 : 32'd0);
    clear_stim(); sc[2] = 4; sc[3] = 2; sc[4] = 1;
    watch(40);
    check_val("t6_max_cleared", max_at2, 0);
    check_val("t6_max2", max_score_o, MAX_EN ? 32'd4 : 32'd0);

    // 7: reset overrides a run in progress
    clear_stim(); ref_len_i = 16'd4;
    start_i = 1'b1; tick(); start_i = 1'b0; tick(); tick();
    check_val("t7_busy_run", busy_o, 1);
    rst = 1'b1; start_i = 1'b1; abort_i = 1'b1;
    tick();
    check_val("t7_rst_state", {busy_o, pe_en_o, pe_rst_o}, 3'b001);
    rst = 1'b0; idle_inputs();
    tick(); tick();
    check_val("t7_after_rst", {busy_o, pe_rst_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dna_array_ctrl.md
DNA_ARRAY_CTRL -- requirements
Module: dna_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_PE, default 16, number of chained PEs (drain length).
REQ-002 SHALL have parameter LEN_W, default 16, width of reference-length counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  in  1  begin one alignment run (sampled in IDLE only).
REQ-006 SHALL have port abort_i  in  1  terminate run, return to IDLE.
REQ-007 SHALL have port ref_len_i  in  LEN_W  reference bases to stream.
REQ-008 SHALL have port match_i / mismatch_i / gap_i  in  3 each  scoring weights.
REQ-009 SHALL have port ref_valid_i / ref_base_i / ref_ready_o  in/in/out  1/2/1  reference base stream.
REQ-010 SHALL have port read_valid_i / read_base_i / read_ready_o  in/in/out  1/2/1  read base stream.
REQ-011 SHALL have port pe_rst_o / pe_en_o  out  1 each  array clear and step enable.
REQ-012 SHALL have port pe_ref_o / pe_read_o  out  2 each  bases to PE0 / broadcast read.
REQ-013 SHALL have port pe_match_o / pe_mismatch_o / pe_gap_o  out  3 each  latched weights.
REQ-014 SHALL have port score_i  in  32  score from last PE.
REQ-015 SHALL have port busy_o / done_o / max_score_o  out  1/1/32  status, one-cycle completion, best score.

Function
REQ-016 SHALL implement FSM IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
REQ-017 SHALL, in IDLE with start_i=1, latch ref_len_i and weights and enter CLEAR next cycle.
REQ-018 SHALL hold pe_rst_o=1 for exactly one cycle in CLEAR, then enter RUN (DRAIN if latched length 0).
REQ-019 SHALL keep 4-bit phase counter, 0 after CLEAR, incrementing per step, wrapping 15->0.
REQ-020 SHALL, in RUN, step iff ref_valid_i=1 and (phase!=15 or read_valid_i=1).
REQ-021 SHALL on a step assert pe_en_o, ref_ready_o, and read_ready_o only when phase=15; all combinational same-cycle.
REQ-022 SHALL hold pe_en_o=0 and both readies 0 on stall; phase and counters unchanged.
REQ-023 SHALL drive pe_ref_o=ref_base_i and pe_read_o=read_base_i during RUN, 2'b11 / 2'b00 otherwise.
REQ-024 SHALL count RUN steps; after step ref_len enter DRAIN next cycle.
REQ-025 SHALL, in DRAIN, step unconditionally each cycle (pe_en_o=1, readies 0) for NUM_PE cycles, then DONE.
REQ-026 SHALL pulse done_o for one cycle in DONE; busy_o=1 in CLEAR, RUN, DRAIN, DONE.
REQ-027 SHALL ignore start_i when not IDLE.
REQ-028 SHALL, on abort_i in any non-IDLE state, go to IDLE next cycle, assert pe_rst_o that cycle, no done_o; abort wins over step.
REQ-029 SHALL hold pe_match_o/pe_mismatch_o/pe_gap_o at latched values until next start.

Reset
REQ-030 SHALL on rst: state IDLE, phase 0, counters 0, max_score_o 0, weights 0, all outputs 0 except pe_rst_o=1 and pe_ref_o=2'b11.
REQ-031 SHALL let rst override start_i and abort_i mid-run.

Configuration
REQ-032 SHALL with DNA_MAXSCORE_EN defined track max_score_o: cleared in CLEAR, updated to score_i when pe_en_o=1 and score_i>max (unsigned), held after DONE.
REQ-033 SHALL without DNA_MAXSCORE_EN tie max_score_o to 0 and omit comparator.

Structure
REQ-034 SHALL place FSM state enum, phase width (4) and filler base codes in shared package dna_pkg.
REQ-035 SHALL be a single module; no sub-module required.

Verification
REQ-036 SHALL test: ref_len=4, streams always valid -> CLEAR 1 cycle, 4 RUN steps, 16 DRAIN, done_o at cycle 22 after start.
REQ-037 SHALL test: ref_valid_i low 3 cycles mid-RUN -> pe_en_o low 3 cycles, phase frozen, done_o delayed by 3.
REQ-038 SHALL test: ref_len=20, read_valid_i low at phase 15 -> stall until read valid; read_ready_o exactly once per 16 steps.
REQ-039 SHALL test: ref_len=0 -> CLEAR then DRAIN 16 cycles, no ref_ready_o, done_o.
REQ-040 SHALL test: abort_i at RUN step 2 -> IDLE next cycle, pe_rst_o=1, no done_o; new start accepted.
REQ-041 SHALL test: DNA_MAXSCORE_EN, score_i sequence 5,9,3 on steps -> max_score_o=9; second run restarts from 0.
